mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDRESS_WIDTH, `ADDRESS_WIDTH, address width.
- DATA_WIDTH, `DATA_WIDTH, memory cell width.
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch waits.
- TIMEOUT_CYCLES, 255, cycles allowed for a memory response.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: the single clock.
- reset_n in 1: asynchronous, active-low reset.
- i_f_addr_valid in 1: fetch request, held high until served.
- i_f_addr in ADDRESS_WIDTH: fetch address.
- o_f_mem_valid out 1: fetch response strobe.
- o_f_mem_data out DATA_WIDTH: fetch read data.
- i_d_req in 1: data-port request, held high until served.
- i_d_we in 1: data-port write enable.
- i_d_addr in ADDRESS_WIDTH: data-port address.
- i_d_wdata in DATA_WIDTH: data-port write data.
- o_d_valid out 1: data-port completion strobe.
- o_d_rdata out DATA_WIDTH: data-port read data.
- o_mem_addr_valid out 1: memory request.
- o_mem_addr out ADDRESS_WIDTH: memory address.
- o_mem_we out 1: memory write enable.
- o_mem_wdata out DATA_WIDTH: memory write data.
- i_mem_valid in 1: memory response or acknowledge.
- i_mem_data in DATA_WIDTH: memory read data.
- o_timeout out 1: one-cycle pulse when a memory access is abandoned.

Function
REQ-003 States SHALL be IDLE, GAP, BUSY_F, BUSY_D, held in a 2-bit registered state.
REQ-004 IDLE: if i_d_req=1 and not (i_f_addr_valid=1 and starve_cnt=STARVE_LIMIT), the block SHALL go to BUSY_D; else if i_f_addr_valid=1 it SHALL go to BUSY_F; else it SHALL stay in IDLE.
REQ-005 On a grant, o_mem_addr, o_mem_we and o_mem_wdata SHALL be registered from the winner's inputs at the grant edge; o_mem_we SHALL be 0 for fetch.
REQ-006 o_mem_addr_valid SHALL be 1 exactly while the state is BUSY_F or BUSY_D, so the first memory request cycle is one cycle after the grant edge.
REQ-007 Memory outputs SHALL stay stable throughout BUSY; the requester's inputs are not resampled.
REQ-008 In BUSY_F with i_mem_valid=1:
- o_f_mem_valid=1 and o_f_mem_data=i_mem_data, combinationally in the same cycle.
- Next state SHALL be GAP.
REQ-009 In BUSY_D with i_mem_valid=1:
- o_d_valid=1 and o_d_rdata=i_mem_data (undefined for writes), combinationally in the same cycle.
- Next state SHALL be GAP.
REQ-010 Outside those cycles, o_f_mem_valid and o_d_valid SHALL be 0 and the data outputs SHALL be 0.
REQ-011 GAP SHALL last exactly one cycle with no grant, so the just-served requester can drop its request; GAP SHALL go to IDLE.
REQ-012 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL behave as follows:
- It SHALL increment on a data grant made while i_f_addr_valid=1.
- It SHALL clear on a fetch grant.
- It SHALL saturate at STARVE_LIMIT.
REQ-013 tmo_cnt (8 bits) SHALL clear at every grant and increment every BUSY cycle with i_mem_valid=0.
REQ-014 On reaching TIMEOUT_CYCLES, the block SHALL:
- drop o_mem_addr_valid;
- pulse o_timeout for one cycle;
- assert the owner's valid with zero data in that cycle;
- go to GAP.
REQ-015 If i_mem_valid and the timeout occur in the same cycle, the response SHALL win and o_timeout SHALL stay 0.
REQ-016 i_mem_valid in IDLE or GAP SHALL be ignored, with no strobe to either requester.
REQ-017 Worst-case fetch wait from request to grant SHALL be STARVE_LIMIT data accesses.

Reset
REQ-018 While reset_n=0, asynchronously:
- state SHALL be IDLE;
- starve_cnt and tmo_cnt SHALL be 0;
- all outputs SHALL be 0.
REQ-019 Reset asserted mid-access SHALL abandon the access with no strobe to the requester; after reset_n rises, the first grant SHALL be possible on the first clock edge.

Structure
REQ-020 State encodings, STARVE_LIMIT and TIMEOUT_CYCLES defaults SHALL live in header.v alongside `ADDRESS_WIDTH/`DATA_WIDTH.
REQ-021 The block SHALL be a single module; the starvation/priority selection MAY be a sub-module arb_pick (combinational winner select).

Verification
REQ-022 Fetch-only read: i_f_addr=0x10; memory responds 3 cycles after o_mem_addr_valid with 0xDEADBEEF -> o_f_mem_valid for 1 cycle with 0xDEADBEEF, then GAP, then IDLE.
REQ-023 Simultaneous requests, fresh reset: fetch 0x20 and data write 0x40=0x12345678 -> data is granted first (o_mem_we=1, addr 0x40), then fetch 0x20.
REQ-024 Starvation: i_d_req held high with back-to-back requests while fetch waits -> exactly 4 data grants, then a fetch grant, and starve_cnt returns to 0.
REQ-025 Timeout: data read at 0x80 with i_mem_valid never asserted -> after 255 BUSY cycles, o_timeout pulses once, o_d_valid=1 with rdata=0, and o_mem_addr_valid drops.
REQ-026 Boundary: i_mem_valid asserted in the cycle tmo_cnt hits 255 -> normal response delivered, o_timeout=0.
REQ-027 Reset mid-access: reset_n pulled low during BUSY_F -> all outputs 0 immediately, no o_f_mem_valid, next grant succeeds after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// State encodings and parameter defaults live here.
package mem_arbiter_pkg;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_DEF   = 4;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        BUSY_F = 2'd2,
        BUSY_D = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select: data wins unless fetch has
// waited through the full starvation budget.
module arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_DEF,
    parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          en,
    input  logic          f_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve_cnt,
    output logic          grant_f,
    output logic          grant_d
);

    logic starved;

    always_comb begin
        starved = f_req && (starve_cnt == SW'(STARVE_LIMIT));
        grant_d = en && d_req && !starved;
        grant_f = en && f_req && !grant_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch and data) with starvation
// bound, one-cycle turnaround gap and response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = ADDR_W,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int STARVE_LIMIT   = STARVE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_f_addr_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_f_addr,
    output logic                     o_f_mem_valid,
    output logic [DATA_WIDTH-1:0]    o_f_mem_data,
    input  logic                     i_d_req,
    input  logic                     i_d_we,
    input  logic [ADDRESS_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0]    i_d_wdata,
    output logic                     o_d_valid,
    output logic [DATA_WIDTH-1:0]    o_d_rdata,
    output logic                     o_mem_addr_valid,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic                     o_mem_we,
    output logic [DATA_WIDTH-1:0]    o_mem_wdata,
    input  logic                     i_mem_valid,
    input  logic [DATA_WIDTH-1:0]    i_mem_data,
    output logic                     o_timeout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    tmo_cnt;
    logic          grant_f, grant_d;
    logic          busy, tmo_fire, done;

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .SW          (SW)
    ) u_pick (
        .en        (state == IDLE),
        .f_req     (i_f_addr_valid),
        .d_req     (i_d_req),
        .starve_cnt(starve_cnt),
        .grant_f   (grant_f),
        .grant_d   (grant_d)
    );

    always_comb begin
        busy      = (state == BUSY_F) || (state == BUSY_D);
        // A response arriving in the expiry cycle takes precedence.
        tmo_fire  = busy && !i_mem_valid
                    && (tmo_cnt == 8'(TIMEOUT_CYCLES));
        done      = busy && (i_mem_valid || tmo_fire);
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d)      state_nxt = BUSY_D;
                else if (grant_f) state_nxt = BUSY_F;
            end
            GAP:    state_nxt = IDLE;
            BUSY_F: if (done) state_nxt = GAP;
            BUSY_D: if (done) state_nxt = GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_mem_addr_valid = busy && !tmo_fire;
        o_timeout        = tmo_fire;
        o_f_mem_valid    = (state == BUSY_F) && done;
        o_d_valid        = (state == BUSY_D) && done;
        o_f_mem_data     = '0;
        o_d_rdata        = '0;
        if (o_f_mem_valid && i_mem_valid) o_f_mem_data = i_mem_data;
        if (o_d_valid && i_mem_valid)     o_d_rdata    = i_mem_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end else if (grant_d) begin
            o_mem_addr  <= i_d_addr;
            o_mem_we    <= i_d_we;
            o_mem_wdata <= i_d_wdata;
        end else if (grant_f) begin
            o_mem_addr  <= i_f_addr;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_f) begin
            starve_cnt <= '0;
        end else if (grant_d && i_f_addr_valid
                     && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (grant_f || grant_d) begin
            tmo_cnt <= '0;
        end else if (busy && !i_mem_valid) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, priority, starvation,
// timeout, timeout/response race and reset mid-access.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_f_addr_valid;
    logic [31:0] i_f_addr;
    logic        o_f_mem_valid;
    logic [31:0] o_f_mem_data;
    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic        o_d_valid;
    logic [31:0] o_d_rdata;
    logic        o_mem_addr_valid;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [31:0] o_mem_wdata;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;
    logic        o_timeout;

    int total = 0;
    int bad   = 0;
    int pulses;

    mem_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_f_addr_valid  (i_f_addr_valid),
        .i_f_addr        (i_f_addr),
        .o_f_mem_valid   (o_f_mem_valid),
        .o_f_mem_data    (o_f_mem_data),
        .i_d_req         (i_d_req),
        .i_d_we          (i_d_we),
        .i_d_addr        (i_d_addr),
        .i_d_wdata       (i_d_wdata),
        .o_d_valid       (o_d_valid),
        .o_d_rdata       (o_d_rdata),
        .o_mem_addr_valid(o_mem_addr_valid),
        .o_mem_addr      (o_mem_addr),
        .o_mem_we        (o_mem_we),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_valid     (i_mem_valid),
        .i_mem_data      (i_mem_data),
        .o_timeout       (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        i_f_addr_valid = 1'b0;
        i_f_addr       = '0;
        i_d_req        = 1'b0;
        i_d_we         = 1'b0;
        i_d_addr       = '0;
        i_d_wdata      = '0;
        i_mem_valid    = 1'b0;
        i_mem_data     = '0;
        #3;
        chk("rst_state", 64'(dut.state), 64'd0);
        chk("rst_mav", 64'(o_mem_addr_valid), 64'd0);
        chk("rst_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_tmo", 64'(o_timeout), 64'd0);
        chk("rst_starve", 64'(dut.starve_cnt), 64'd0);
        tick();
        reset_n = 1'b1;

        // fetch-only read, memory answers on the 4th request cycle
        tick();
        i_f_addr_valid = 1'b1;
        i_f_addr       = 32'h10;
        tick();
        #1;
        chk("f_mav", 64'(o_mem_addr_valid), 64'd1);
        chk("f_addr", 64'(o_mem_addr), 64'h10);
        chk("f_we", 64'(o_mem_we), 64'd0);
        chk("f_early", 64'(o_f_mem_valid), 64'd0);
        tick();
        tick();
        tick();
        i_mem_valid = 1'b1;
        i_mem_data  = 32'hDEADBEEF;
        #1;
        chk("f_valid", 64'(o_f_mem_valid), 64'd1);
        chk("f_data", 64'(o_f_mem_data), 64'hDEADBEEF);
        tick();
        i_f_addr_valid = 1'b0;
        i_mem_data     = 32'hCAFE;
        #1;
        chk("gap_state", 64'(dut.state), 64'd1);
        chk("gap_fv", 64'(o_f_mem_valid), 64'd0);
        chk("gap_dv", 64'(o_d_valid), 64'd0);
        chk("gap_fdata", 64'(o_f_mem_data), 64'd0);
        chk("gap_mav", 64'(o_mem_addr_valid), 64'd0);
        tick();
        i_mem_valid = 1'b0;
        #1;
        chk("idle_state", 64'(dut.state), 64'd0);

        // simultaneous requests after fresh reset: data first
        reset_n = 1'b0;
        #1;
        reset_n        = 1'b1;
        i_f_addr_valid = 1'b1;
        i_f_addr       = 32'h20;
        i_d_req        = 1'b1;
        i_d_we         = 1'b1;
        i_d_addr       = 32'h40;
        i_d_wdata      = 32'h12345678;
        tick();
        chk("pr_state", 64'(dut.state), 64'd3);
        chk("pr_addr", 64'(o_mem_addr), 64'h40);
        chk("pr_we", 64'(o_mem_we), 64'd1);
        chk("pr_wdata", 64'(o_mem_wdata), 64'h12345678);
        chk("pr_starve", 64'(dut.starve_cnt), 64'd1);
        i_mem_valid = 1'b1;
        #1;
        chk("pr_dv", 64'(o_d_valid), 64'd1);
        tick();
        i_d_req     = 1'b0;
        i_mem_valid = 1'b0;
        tick();
        tick();
        chk("pr_f_state", 64'(dut.state), 64'd2);
        chk("pr_f_addr", 64'(o_mem_addr), 64'h20);
        chk("pr_f_we", 64'(o_mem_we), 64'd0);
        chk("pr_f_starve", 64'(dut.starve_cnt), 64'd0);
        i_mem_valid = 1'b1;
        i_mem_data  = 32'h55;
        #1;
        chk("pr_f_data", 64'(o_f_mem_data), 64'h55);
        tick();
        i_f_addr_valid = 1'b0;
        i_mem_valid    = 1'b0;
        tick();

        // starvation: data held high, fetch waits four data grants
        i_f_addr_valid = 1'b1;
        i_f_addr       = 32'h30;
        i_d_req        = 1'b1;
        i_d_we         = 1'b0;
        i_d_addr       = 32'h50;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("sv_state", 64'(dut.state), 64'd3);
            chk("sv_addr", 64'(o_mem_addr), 64'h50);
            chk("sv_starve", 64'(dut.starve_cnt), 64'(k));
            i_mem_valid = 1'b1;
            i_mem_data  = 32'(k);
            #1;
            chk("sv_rdata", 64'(o_d_rdata), 64'(k));
            tick();
            i_mem_valid = 1'b0;
            tick();
        end
        tick();
        chk("sv_f_state", 64'(dut.state), 64'd2);
        chk("sv_f_addr", 64'(o_mem_addr), 64'h30);
        chk("sv_f_starve", 64'(dut.starve_cnt), 64'd0);
        i_mem_valid = 1'b1;
        #1;
        chk("sv_f_valid", 64'(o_f_mem_valid), 64'd1);
        tick();
        i_mem_valid    = 1'b0;
        i_f_addr_valid = 1'b0;
        i_d_req        = 1'b0;
        tick();

        // timeout: data read never answered
        i_d_req    = 1'b1;
        i_d_addr   = 32'h80;
        i_mem_data = 32'hFFFF;
        tick();
        chk("to_addr", 64'(o_mem_addr), 64'h80);
        pulses = 0;
        for (int n = 0; n < 254; n++) begin
            if (o_timeout) pulses++;
            if (o_d_valid) pulses++;
            tick();
        end
        chk("to_quiet", 64'(pulses), 64'd0);
        chk("to_mav_pre", 64'(o_mem_addr_valid), 64'd1);
        tick();
        chk("to_pulse", 64'(o_timeout), 64'd1);
        chk("to_dv", 64'(o_d_valid), 64'd1);
        chk("to_rdata", 64'(o_d_rdata), 64'd0);
        chk("to_mav", 64'(o_mem_addr_valid), 64'd0);
        tick();
        i_d_req = 1'b0;
        #1;
        chk("to_once", 64'(o_timeout), 64'd0);
        chk("to_gap", 64'(dut.state), 64'd1);
        tick();

        // response arrives in the expiry cycle
        i_d_req  = 1'b1;
        i_d_addr = 32'h84;
        tick();
        for (int n = 0; n < 254; n++) tick();
        tick();
        i_mem_valid = 1'b1;
        i_mem_data  = 32'hA5A5;
        #1;
        chk("race_cnt", 64'(dut.tmo_cnt), 64'd255);
        chk("race_tmo", 64'(o_timeout), 64'd0);
        chk("race_dv", 64'(o_d_valid), 64'd1);
        chk("race_rdata", 64'(o_d_rdata), 64'hA5A5);
        tick();
        i_d_req     = 1'b0;
        i_mem_valid = 1'b0;
        tick();

        // reset during a fetch access
        i_f_addr_valid = 1'b1;
        i_f_addr       = 32'h90;
        tick();
        chk("rm_mav_pre", 64'(o_mem_addr_valid), 64'd1);
        i_mem_valid = 1'b1;
        i_mem_data  = 32'h77;
        reset_n     = 1'b0;
        #1;
        chk("rm_mav", 64'(o_mem_addr_valid), 64'd0);
        chk("rm_addr", 64'(o_mem_addr), 64'd0);
        chk("rm_fv", 64'(o_f_mem_valid), 64'd0);
        chk("rm_fdata", 64'(o_f_mem_data), 64'd0);
        tick();
        i_mem_valid = 1'b0;
        reset_n     = 1'b1;
        tick();
        chk("rm_regrant", 64'(dut.state), 64'd2);
        chk("rm_addr2", 64'(o_mem_addr), 64'h90);
        i_mem_valid = 1'b1;
        i_mem_data  = 32'h99;
        #1;
        chk("rm_fdata2", 64'(o_f_mem_data), 64'h99);
        tick();
        i_mem_valid    = 1'b0;
        i_f_addr_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
